// File: rtl/player_movement.sv
`default_nettype none
// ============================================================================
//  Module   : player_movement
//  Purpose  : Steps the player sprite one pixel per rising edge of the
//             move-rate signal in the direction of the held push-buttons,
//             clamped to the playfield edges.
//  Revision : 1.0  initial release
// ============================================================================
module player_movement #(
  parameter int SCREEN_W = 96,
  parameter int SCREEN_H = 64,
  parameter int PLAYER_W = 8,
  parameter int PLAYER_H = 8,
  parameter int SPAWN_X  = 44,
  parameter int SPAWN_Y  = 28
) (
  input  logic       clock_100mhz,
  input  logic       reset,
  input  logic       game_active,
  input  logic       clock_player_move,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  output logic [6:0] player_x,
  output logic [5:0] player_y,
  output logic       move_strobe,
  output logic       hit_wall
);

  localparam logic signed [7:0] X_MAX = 8'(SCREEN_W - PLAYER_W);
  localparam logic signed [7:0] Y_MAX = 8'(SCREEN_H - PLAYER_H);

  // Button vector order: [3]=U, [2]=D, [1]=L, [0]=R
  localparam int B_U = 3;
  localparam int B_D = 2;
  localparam int B_L = 1;
  localparam int B_R = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPAWN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [3:0] btn_m;
  logic [3:0] btn_s;
  logic       mv_q;
  logic       mv_prev;
  logic       tick;

  logic signed [7:0] dx, dy;
  logic signed [7:0] sum_x, sum_y;
  logic [6:0]        next_x;
  logic [5:0]        next_y;
  logic              x_block, y_block;

  // Two-flop synchronizers for the asynchronous push-buttons
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      btn_m <= 4'b0000;
      btn_s <= 4'b0000;
    end else begin
      btn_m <= {btnU, btnD, btnL, btnR};
      btn_s <= btn_m;
    end
  end

  // Register the move-rate signal and keep one older copy for edge detection.
  // mv_prev tracks mv_q in every state, so entering ACTIVE never sees a stale
  // edge from before the game started.
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      mv_q    <= 1'b0;
      mv_prev <= 1'b0;
    end else begin
      mv_q    <= clock_player_move;
      mv_prev <= mv_q;
    end
  end

  assign tick = mv_q & ~mv_prev;

  // Per-axis step request and edge clamping in 8-bit signed arithmetic
  always_comb begin
    dx = 8'sd0;
    dy = 8'sd0;
    if (btn_s[B_R] && !btn_s[B_L]) dx = 8'sd1;
    else if (btn_s[B_L] && !btn_s[B_R]) dx = -8'sd1;
    if (btn_s[B_D] && !btn_s[B_U]) dy = 8'sd1;
    else if (btn_s[B_U] && !btn_s[B_D]) dy = -8'sd1;

    sum_x = signed'({1'b0, player_x}) + dx;
    sum_y = signed'({2'b00, player_y}) + dy;

    next_x  = player_x;
    x_block = 1'b0;
    if (sum_x < 8'sd0) begin
      next_x  = 7'd0;
      x_block = 1'b1;
    end else if (sum_x > X_MAX) begin
      next_x  = X_MAX[6:0];
      x_block = 1'b1;
    end else begin
      next_x  = sum_x[6:0];
    end

    next_y  = player_y;
    y_block = 1'b0;
    if (sum_y < 8'sd0) begin
      next_y  = 6'd0;
      y_block = 1'b1;
    end else if (sum_y > Y_MAX) begin
      next_y  = Y_MAX[5:0];
      y_block = 1'b1;
    end else begin
      next_y  = sum_y[5:0];
    end
  end

  // State register
  always_ff @(posedge clock_100mhz) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; dropping game_active wins over any tick in ACTIVE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (game_active) state_next = SPAWN;
      SPAWN:   state_next = ACTIVE;
      ACTIVE:  if (!game_active) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Position register and single-cycle status pulses
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      player_x    <= 7'(SPAWN_X);
      player_y    <= 6'(SPAWN_Y);
      move_strobe <= 1'b0;
      hit_wall    <= 1'b0;
    end else begin
      move_strobe <= 1'b0;
      hit_wall    <= 1'b0;
      case (state)
        IDLE, SPAWN: begin
          player_x <= 7'(SPAWN_X);
          player_y <= 6'(SPAWN_Y);
        end
        ACTIVE: begin
          if (game_active && tick) begin
            player_x    <= next_x;
            player_y    <= next_y;
            move_strobe <= (next_x != player_x) || (next_y != player_y);
            hit_wall    <= x_block | y_block;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_player_movement.sv
`default_nettype none
// ============================================================================
//  Module   : tb_player_movement
//  Purpose  : Directed self-checking bench for player_movement.
//  Revision : 1.0  initial release
// ============================================================================
module tb_player_movement;

  logic       clk;
  logic       reset;
  logic       game_active;
  logic       cmove;
  logic       btnU, btnD, btnL, btnR;
  logic [6:0] player_x;
  logic [5:0] player_y;
  logic       move_strobe;
  logic       hit_wall;

  int total = 0;
  int bad   = 0;

  // Values captured by the pulse task
  logic [6:0] obs_x;
  logic [5:0] obs_y;
  logic       obs_ms, obs_hw, obs_pre, obs_post;

  player_movement dut (
    .clock_100mhz      (clk),
    .reset             (reset),
    .game_active       (game_active),
    .clock_player_move (cmove),
    .btnU              (btnU),
    .btnD              (btnD),
    .btnL              (btnL),
    .btnR              (btnR),
    .player_x          (player_x),
    .player_y          (player_y),
    .move_strobe       (move_strobe),
    .hit_wall          (hit_wall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock edges, landing 1ns after the last edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One move-rate pulse, 2 cycles high and 2 low; captures outputs
  // one cycle after the rise (pre), two cycles after (main) and three (post)
  task automatic pulse();
    cmove = 1'b1;
    cycles(1);
    obs_pre = move_strobe | hit_wall;
    cycles(1);
    obs_x  = player_x;
    obs_y  = player_y;
    obs_ms = move_strobe;
    obs_hw = hit_wall;
    cmove  = 1'b0;
    cycles(1);
    obs_post = move_strobe | hit_wall;
    cycles(1);
  endtask

  task automatic test_reset();
    reset = 1'b1; game_active = 1'b0; cmove = 1'b1;
    btnU = 1'b0; btnD = 1'b0; btnL = 1'b0; btnR = 1'b0;
    cycles(2);
    total++;
    if (player_x !== 7'd44 || player_y !== 6'd28 || move_strobe !== 1'b0 || hit_wall !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got x=%0d y=%0d ms=%b hw=%b, want x=44 y=28 ms=0 hw=0",
               player_x, player_y, move_strobe, hit_wall);
    end
    reset = 1'b0;
    cycles(2);
    total++;
    if (player_x !== 7'd44 || player_y !== 6'd28 || move_strobe !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: got x=%0d y=%0d ms=%b, want x=44 y=28 ms=0",
               player_x, player_y, move_strobe);
    end
  endtask

  task automatic test_no_buttons();
    game_active = 1'b1;
    cycles(1);
    cmove = 1'b0;
    cycles(2);
    for (int i = 1; i <= 10; i++) begin
      pulse();
      total++;
      if (obs_x !== 7'd44 || obs_y !== 6'd28 || obs_ms !== 1'b0 || obs_hw !== 1'b0) begin
        bad++;
        $display("FAIL no_buttons tick %0d: got x=%0d y=%0d ms=%b hw=%b, want x=44 y=28 ms=0 hw=0",
                 i, obs_x, obs_y, obs_ms, obs_hw);
      end
    end
  endtask

  task automatic test_right();
    btnR = 1'b1;
    cycles(3);
    for (int i = 1; i <= 5; i++) begin
      pulse();
      total++;
      if (obs_pre !== 1'b0 || obs_x !== 7'(44 + i) || obs_y !== 6'd28 ||
          obs_ms !== 1'b1 || obs_hw !== 1'b0 || obs_post !== 1'b0) begin
        bad++;
        $display("FAIL right tick %0d: got pre=%b x=%0d y=%0d ms=%b hw=%b post=%b, want pre=0 x=%0d y=28 ms=1 hw=0 post=0",
                 i, obs_pre, obs_x, obs_y, obs_ms, obs_hw, obs_post, 44 + i);
      end
    end
  endtask

  task automatic test_left();
    btnR = 1'b0; btnL = 1'b1;
    // Restart the game to return to the spawn point
    game_active = 1'b0; cmove = 1'b1;
    cycles(3);
    game_active = 1'b1;
    cycles(2);
    total++;
    if (player_x !== 7'd44 || player_y !== 6'd28) begin
      bad++;
      $display("FAIL respawn: got x=%0d y=%0d, want x=44 y=28", player_x, player_y);
    end
    cmove = 1'b0;
    cycles(2);
    for (int i = 1; i <= 50; i++) begin
      pulse();
      total++;
      if (i <= 44) begin
        if (obs_x !== 7'(44 - i) || obs_ms !== 1'b1 || obs_hw !== 1'b0) begin
          bad++;
          $display("FAIL left tick %0d: got x=%0d ms=%b hw=%b, want x=%0d ms=1 hw=0",
                   i, obs_x, obs_ms, obs_hw, 44 - i);
        end
      end else begin
        if (obs_x !== 7'd0 || obs_ms !== 1'b0 || obs_hw !== 1'b1) begin
          bad++;
          $display("FAIL left_wall tick %0d: got x=%0d ms=%b hw=%b, want x=0 ms=0 hw=1",
                   i, obs_x, obs_ms, obs_hw);
        end
      end
    end
  endtask

  task automatic test_diagonal();
    btnL = 1'b0; btnD = 1'b1; btnR = 1'b1;
    cycles(3);
    for (int i = 1; i <= 27; i++) begin
      pulse();
      total++;
      if (obs_x !== 7'(i) || obs_y !== 6'(28 + i) || obs_ms !== 1'b1 || obs_hw !== 1'b0) begin
        bad++;
        $display("FAIL diag tick %0d: got x=%0d y=%0d ms=%b hw=%b, want x=%0d y=%0d ms=1 hw=0",
                 i, obs_x, obs_y, obs_ms, obs_hw, i, 28 + i);
      end
    end
    btnD = 1'b0;
    cycles(3);
    for (int i = 1; i <= 60; i++) begin
      pulse();
      total++;
      if (obs_x !== 7'(27 + i) || obs_y !== 6'd55 || obs_ms !== 1'b1) begin
        bad++;
        $display("FAIL run_right tick %0d: got x=%0d y=%0d ms=%b, want x=%0d y=55 ms=1",
                 i, obs_x, obs_y, obs_ms, 27 + i);
      end
    end
    btnD = 1'b1;
    cycles(3);
    pulse();
    total++;
    if (obs_x !== 7'd88 || obs_y !== 6'd56 || obs_ms !== 1'b1 || obs_hw !== 1'b0) begin
      bad++;
      $display("FAIL corner_reach: got x=%0d y=%0d ms=%b hw=%b, want x=88 y=56 ms=1 hw=0",
               obs_x, obs_y, obs_ms, obs_hw);
    end
    pulse();
    total++;
    if (obs_x !== 7'd88 || obs_y !== 6'd56 || obs_ms !== 1'b0 || obs_hw !== 1'b1) begin
      bad++;
      $display("FAIL corner_block: got x=%0d y=%0d ms=%b hw=%b, want x=88 y=56 ms=0 hw=1",
               obs_x, obs_y, obs_ms, obs_hw);
    end
  endtask

  task automatic test_wall_slide_and_opposing();
    // Up-right against the right wall: y moves, x blocked
    btnD = 1'b0; btnU = 1'b1;
    cycles(3);
    pulse();
    total++;
    if (obs_x !== 7'd88 || obs_y !== 6'd55 || obs_ms !== 1'b1 || obs_hw !== 1'b1) begin
      bad++;
      $display("FAIL wall_slide: got x=%0d y=%0d ms=%b hw=%b, want x=88 y=55 ms=1 hw=1",
               obs_x, obs_y, obs_ms, obs_hw);
    end
    // Up and down together cancel
    btnR = 1'b0; btnD = 1'b1;
    cycles(3);
    pulse();
    total++;
    if (obs_x !== 7'd88 || obs_y !== 6'd55 || obs_ms !== 1'b0 || obs_hw !== 1'b0) begin
      bad++;
      $display("FAIL opposing_ud: got x=%0d y=%0d ms=%b hw=%b, want x=88 y=55 ms=0 hw=0",
               obs_x, obs_y, obs_ms, obs_hw);
    end
  endtask

  task automatic test_stuck_high();
    int strobes;
    btnD = 1'b0;
    cycles(3);
    cmove = 1'b1;
    cycles(2);
    total++;
    if (player_y !== 6'd54 || player_x !== 7'd88 || move_strobe !== 1'b1) begin
      bad++;
      $display("FAIL stuck_first_step: got x=%0d y=%0d ms=%b, want x=88 y=54 ms=1",
               player_x, player_y, move_strobe);
    end
    strobes = 0;
    for (int i = 0; i < 998; i++) begin
      cycles(1);
      if (move_strobe === 1'b1) strobes++;
    end
    total++;
    if (strobes !== 0 || player_y !== 6'd54) begin
      bad++;
      $display("FAIL stuck_high_hold: got extra_strobes=%0d y=%0d, want extra_strobes=0 y=54",
               strobes, player_y);
    end
    cmove = 1'b0;
    cycles(2);
  endtask

  task automatic test_mid_game();
    btnU = 1'b0; btnL = 1'b1;
    cycles(3);
    for (int i = 0; i < 38; i++) pulse();
    btnL = 1'b0; btnU = 1'b1;
    cycles(3);
    for (int i = 0; i < 34; i++) pulse();
    total++;
    if (player_x !== 7'd50 || player_y !== 6'd20) begin
      bad++;
      $display("FAIL reach_50_20: got x=%0d y=%0d, want x=50 y=20", player_x, player_y);
    end
    btnU = 1'b0;
    game_active = 1'b0; cmove = 1'b1;
    cycles(4);
    game_active = 1'b1;
    cycles(2);
    total++;
    if (player_x !== 7'd44 || player_y !== 6'd28 || move_strobe !== 1'b0) begin
      bad++;
      $display("FAIL regame_spawn: got x=%0d y=%0d ms=%b, want x=44 y=28 ms=0",
               player_x, player_y, move_strobe);
    end
    cmove = 1'b0;
    cycles(2);
  endtask

  task automatic test_reset_during_tick();
    btnR = 1'b1;
    cycles(3);
    for (int i = 0; i < 3; i++) pulse();
    total++;
    if (player_x !== 7'd47) begin
      bad++;
      $display("FAIL pre_reset_pos: got x=%0d, want x=47", player_x);
    end
    cmove = 1'b1;
    cycles(1);
    reset = 1'b1;
    cycles(1);
    total++;
    if (player_x !== 7'd44 || player_y !== 6'd28 || move_strobe !== 1'b0 || hit_wall !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_tick: got x=%0d y=%0d ms=%b hw=%b, want x=44 y=28 ms=0 hw=0",
               player_x, player_y, move_strobe, hit_wall);
    end
    reset = 1'b0;
    cycles(4);
    total++;
    if (player_x !== 7'd44 || player_y !== 6'd28 || move_strobe !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_no_spurious: got x=%0d y=%0d ms=%b, want x=44 y=28 ms=0",
               player_x, player_y, move_strobe);
    end
    cmove = 1'b0;
    cycles(2);
    pulse();
    total++;
    if (obs_x !== 7'd45 || obs_ms !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_move: got x=%0d ms=%b, want x=45 ms=1", obs_x, obs_ms);
    end
  endtask

  initial begin
    test_reset();
    test_no_buttons();
    test_right();
    test_left();
    test_diagonal();
    test_wall_slide_and_opposing();
    test_stuck_high();
    test_mid_game();
    test_reset_during_tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/player_movement.md
# player_movement

Consumes the `clock_player_move` rate signal produced by the player speed stage and turns it into player position updates on the 96x64 OLED playfield. Each rising edge of `clock_player_move` advances the player sprite by one pixel in the direction of the held push-buttons, clamped to the screen edges. Outputs feed the sprite renderer and the collision logic.

## Interface
Parameters:
- `SCREEN_W`, 96, playfield width in pixels
- `SCREEN_H`, 64, playfield height in pixels
- `PLAYER_W`, 8, sprite width; max x = `SCREEN_W - PLAYER_W`
- `PLAYER_H`, 8, sprite height; max y = `SCREEN_H - PLAYER_H`
- `SPAWN_X`, 44, x loaded on game start
- `SPAWN_Y`, 28, y loaded on game start

Ports:
- `clock_100mhz`  in  1  system clock; one clock, all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `game_active`  in  1  high while a game is running
- `clock_player_move`  in  1  move-rate signal from the speed stage; held 1 when game inactive, 0 when no speed switch set
- `btnU`, `btnD`, `btnL`, `btnR`  in  1 each  raw push-buttons, asynchronous
- `player_x`  out  7  sprite top-left x
- `player_y`  out  6  sprite top-left y
- `move_strobe`  out  1  one-cycle pulse when position changed
- `hit_wall`  out  1  one-cycle pulse when a requested step was blocked by an edge

## Operation
- Buttons pass through a 2-flop synchronizer each (`btn_s`), reset to 0.
- `clock_player_move` is registered once (`mv_q`) plus a previous copy (`mv_prev`); tick = `mv_q & ~mv_prev`.
- State machine, reset state IDLE:
  - IDLE: position held at SPAWN; `mv_prev <= mv_q`. `game_active`=1 -> SPAWN.
  - SPAWN (one cycle): load `player_x=SPAWN_X`, `player_y=SPAWN_Y`; `mv_prev <= mv_q` so no spurious tick. -> ACTIVE.
  - ACTIVE: on tick, apply step; `game_active`=0 -> IDLE (checked before tick; the tick in that cycle is ignored).
- Step per axis: dx = R - L, dy = D - U (signed, -1/0/+1). Both opposing buttons held -> 0 on that axis. Diagonals allowed (both axes in same tick).
- Clamping per axis, computed in 8-bit signed arithmetic: x at 0 with dx=-1 stays 0; x at `SCREEN_W-PLAYER_W` (88) with dx=+1 stays 88; likewise y with 0 and 56. No wrap-around.
- `move_strobe` = 1 for one cycle if either coordinate changed on the tick.
- `hit_wall` = 1 for one cycle if any nonzero axis request was clamped. Both can be 1 in the same cycle (diagonal into one wall).
- Tick with no buttons: no change, no pulses.
- `clock_player_move` stuck 0 or 1: no ticks, position frozen.

## Timing
- Reset values: `player_x=SPAWN_X`, `player_y=SPAWN_Y`, `move_strobe=0`, `hit_wall=0`, state IDLE, synchronizers and `mv_q`/`mv_prev` cleared to 0.
- `clock_player_move` rises in cycle N -> `mv_q`=1 at N+1 -> position, `move_strobe`, `hit_wall` registered at N+2 (2-cycle latency).
- Button change -> effective for a tick 2 cycles later; button level sampled in the same cycle the tick is detected.
- `game_active` rise at cycle N -> SPAWN at N+1 -> ACTIVE at N+2; earliest move at the first rising edge of `mv_q` after entering SPAWN.
- Reset mid-game: next cycle outputs equal reset values regardless of state or pending tick.
- Maximum one step per rising edge; wide high pulses of `clock_player_move` never produce repeated steps.

## Test plan
- Reset then `game_active`=1, no buttons, 10 ticks -> `player_x=44`, `player_y=28`, `move_strobe` never asserts.
- Hold `btnR`, 5 ticks -> `player_x` steps 45,46,47,48,49, one `move_strobe` per tick at 2-cycle latency, `hit_wall`=0.
- Hold `btnL`, 50 ticks -> `player_x` reaches 0 after 44 ticks; remaining 6 ticks give `hit_wall` pulses, no `move_strobe`.
- Hold `btnD`+`btnR` from (87,55), 2 ticks -> (88,56) with `move_strobe`; then (88,56) with `hit_wall` only. Hold `btnU`+`btnD`: no y change.
- `clock_player_move` held 1 for 1000 cycles with `btnU` -> exactly one step (y 28 -> 27).
- Mid-game: move to (50,20), drop `game_active` -> IDLE; raise again -> position (44,28) two cycles later; assert `reset` during a tick -> tick discarded, outputs at reset values.
